// File: rtl/aes_128_dec.sv
// -----------------------------------------------------------------------------
// aes_128_dec : iterative AES-128 inverse cipher (FIPS-197 decryption).
//
// A block is accepted on the valid/ready handshake. The key is then expanded
// forward to the last round key (10 cycles, one key step per cycle). After
// that the ten inverse rounds run one per cycle while the key schedule is
// rolled back one round key per cycle (11 cycles, including the initial
// AddRoundKey). Accept-to-result latency is 21 clock edges.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   in_ct / in_key valid
//   in_ready   out  1   block idle; transfer on in_valid & in_ready
//   in_ct      in 128   ciphertext, byte 0 at [127:120], column-major
//   in_key     in 128   cipher key, same byte order
//   out_valid  out  1   one-cycle pulse, out newly valid
//   out        out 128  plaintext, held until the next result
//   busy       out  1   key expansion or decryption in progress
// -----------------------------------------------------------------------------

// Forward AES S-box lookup (used for SubWord in the key schedule).
module aes_128_dec_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_y = SBOX[i_a];
endmodule

// Inverse AES S-box lookup (InvSubBytes).
module aes_128_dec_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign o_y = INV_SBOX[i_a];
endmodule

module aes_128_dec (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ct,
  input  logic [127:0] in_key,
  output logic         out_valid,
  output logic [127:0] out,
  output logic         busy
);

  typedef enum logic [1:0] {S_IDLE, S_KEXP, S_DEC} state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] r_st;
  logic [127:0] r_rk;
  logic [7:0]   r_rcon;
  logic [3:0]   r_cnt;
  logic         r_out_valid;
  logic [127:0] r_out;

  // GF(2^8) multiply by x, polynomial 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Divide by x in GF(2^8): (x ^ 0x11b) >> 1 when x is odd, which is
  // (x >> 1) ^ 0x8d since bit 0 drops out.
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    return a[0] ? ({1'b0, a[7:1]} ^ 8'h8d) : {1'b0, a[7:1]};
  endfunction

  // Row r rotates right by r: output byte (r,c) comes from input (r,c-r).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  // One InvMixColumns column; 0e/0b/0d/09 assembled from x2, x4, x8.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31 - 8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
  logic [127:0] w_isr;
  logic [127:0] w_isb;
  logic [127:0] w_round;
  logic [127:0] w_imc;

  assign w_isr = inv_shift_rows(r_st);

  for (genvar g = 0; g < 16; g++) begin : g_isb
    aes_128_dec_inv_sbox u_isb (
      .i_a (w_isr[127 - 8*g -: 8]),
      .o_y (w_isb[127 - 8*g -: 8])
    );
  end

  assign w_round = w_isb ^ r_rk;
  assign w_imc   = inv_mix_columns(w_round);

  // Key schedule. One SubWord(RotWord()) unit serves both directions: going
  // forward it works on w3, going backward on the recovered w3' = w3 ^ w2.
  logic [31:0]  w_k0, w_k1, w_k2, w_k3;
  logic [31:0]  w_sw_in;
  logic [31:0]  w_sw_rot;
  logic [31:0]  w_sw;
  logic [31:0]  w_rc;
  logic [31:0]  w_kf0, w_kf1, w_kf2, w_kf3;
  logic [31:0]  w_kb0, w_kb1, w_kb2, w_kb3;
  logic [127:0] w_rk_fwd;
  logic [127:0] w_rk_bwd;

  assign {w_k0, w_k1, w_k2, w_k3} = r_rk;

  assign w_sw_in  = (r_state == S_DEC) ? (w_k3 ^ w_k2) : w_k3;
  assign w_sw_rot = {w_sw_in[23:0], w_sw_in[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sw
    aes_128_dec_sbox u_sb (
      .i_a (w_sw_rot[31 - 8*g -: 8]),
      .o_y (w_sw[31 - 8*g -: 8])
    );
  end

  assign w_rc = {r_rcon, 24'h0};

  assign w_kf0 = w_k0 ^ w_sw ^ w_rc;
  assign w_kf1 = w_k1 ^ w_kf0;
  assign w_kf2 = w_k2 ^ w_kf1;
  assign w_kf3 = w_k3 ^ w_kf2;
  assign w_rk_fwd = {w_kf0, w_kf1, w_kf2, w_kf3};

  assign w_kb3 = w_k3 ^ w_k2;
  assign w_kb2 = w_k2 ^ w_k1;
  assign w_kb1 = w_k1 ^ w_k0;
  assign w_kb0 = w_k0 ^ w_sw ^ w_rc;
  assign w_rk_bwd = {w_kb0, w_kb1, w_kb2, w_kb3};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_state_nxt = S_KEXP;
      end
      S_KEXP: begin
        if (r_cnt == 4'd9) w_state_nxt = S_DEC;
      end
      S_DEC: begin
        if (r_cnt == 4'd10) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st        <= '0;
      r_rk        <= '0;
      r_rcon      <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_st   <= in_ct;
            r_rk   <= in_key;
            r_rcon <= 8'h01;
            r_cnt  <= 4'd0;
          end
        end
        S_KEXP: begin
          r_rk <= w_rk_fwd;
          // rcon stops at 0x36 so the backward walk starts from the last one.
          if (r_cnt == 4'd9) begin
            r_cnt <= 4'd0;
          end else begin
            r_rcon <= xtime(r_rcon);
            r_cnt  <= r_cnt + 4'd1;
          end
        end
        S_DEC: begin
          if (r_cnt == 4'd0) begin
            r_st <= r_st ^ r_rk;
          end else if (r_cnt < 4'd10) begin
            r_st <= w_imc;
          end else begin
            r_st        <= w_round;
            r_out       <= w_round;
            r_out_valid <= 1'b1;
          end
          if (r_cnt < 4'd10) begin
            r_rk   <= w_rk_bwd;
            r_rcon <= inv_xtime(r_rcon);
            r_cnt  <= r_cnt + 4'd1;
          end else begin
            r_cnt <= 4'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;

endmodule

// File: tb/tb_aes_128_dec.sv
// -----------------------------------------------------------------------------
// Testbench for aes_128_dec. A reference forward cipher (with its S-box
// derived from the GF(2^8) inverse plus affine map) produces ciphertexts for
// random plaintexts; expected plaintexts go into a scoreboard queue at each
// accept and are compared, with latency, when out_valid pulses.
// -----------------------------------------------------------------------------
module tb_aes_128_dec;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_ct;
  logic [127:0] in_key;
  logic         out_valid;
  logic [127:0] out;
  logic         busy;

  aes_128_dec dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ct     (in_ct),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out       (out),
    .busy      (busy)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  typedef struct {
    logic [127:0] pt;
    int           acc;
  } exp_t;

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           acc_count = 0;
  logic [127:0] cur_pt;
  exp_t         sb_q [$];
  logic [7:0]   sbx [256];
  vec_t         tab [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      sbx[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] k;
    logic [31:0]  w0, w1, w2, w3, tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    k  = key;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ key[127 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbx[s[i]];
      for (int row = 0; row < 4; row++)
        for (int c = 0; c < 4; c++)
          s[row + 4*c] = t[row + 4*((c + row) % 4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      w3  = k[31:0];
      tmp = {sbx[w3[23:16]], sbx[w3[15:8]], sbx[w3[7:0]], sbx[w3[31:24]]} ^ {rc, 24'h0};
      w0  = k[127:96] ^ tmp;
      w1  = k[95:64] ^ w0;
      w2  = k[63:32] ^ w1;
      w3  = k[31:0] ^ w2;
      k   = {w0, w1, w2, w3};
      rc  = xt(rc);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL stray_out_valid got out=%h required no pulse", out);
        end else begin
          e = sb_q.pop_front();
          total++;
          if (out !== e.pt) begin
            bad++;
            $display("FAIL result got %h required %h", out, e.pt);
          end
          total++;
          if (cyc != e.acc + 21) begin
            bad++;
            $display("FAIL latency got %0d required 21", cyc - e.acc);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.pt  = cur_pt;
        e.acc = cyc + 1;
        sb_q.push_back(e);
        acc_count++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got %h required %h", name, got, req);
    end
  endtask

  // Called at posedge+1; returns one cycle after the accept edge (+1).
  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout got in_ready=0 required 1");
    end
    in_key   = k;
    in_ct    = c;
    cur_pt   = p;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout got %0d pending required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         ta;
    int         n;
    int         acc0;
    int         seen;
    logic [127:0] k, p;

    build_sbox();
    tab[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
               ct:  128'h3925841d02dc09fbdc118597196a0b32,
               pt:  128'h3243f6a8885a308d313198a2e0370734};
    tab[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
               ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               pt:  128'h00112233445566778899aabbccddeeff};

    // Reset state, with in_valid asserted throughout reset
    rst      = 1'b1;
    in_valid = 1'b1;
    in_key   = tab[0].key;
    in_ct    = tab[0].ct;
    cur_pt   = tab[0].pt;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out", out, 128'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_busy", 128'(busy), 128'd0);
    check("post_rst_accepts", 128'(acc_count), 128'd0);

    // Last round key after forward expansion
    send(tab[0].key, tab[0].ct, tab[0].pt);
    repeat (10) @(posedge clk);
    #1;
    check("kexp_rk", dut.r_rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("kexp_busy", 128'(busy), 128'd1);
    wait_drain();

    // Table-driven known-answer vectors
    for (int i = 0; i < 2; i++) begin
      send(tab[i].key, tab[i].ct, tab[i].pt);
      wait_drain();
    end

    // Round trip through the reference encryption
    for (int i = 0; i < 200; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send(k, enc(k, p), p);
      wait_drain();
    end

    // Back-to-back: in_valid held high across B then C.1
    acc0     = acc_count;
    in_key   = tab[0].key;
    in_ct    = tab[0].ct;
    cur_pt   = tab[0].pt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    ta       = cyc;
    in_key   = tab[1].key;
    in_ct    = tab[1].ct;
    cur_pt   = tab[1].pt;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_ready_cycle", 128'(cyc - ta), 128'd21);
    check("b2b_ready_with_out_valid", 128'(out_valid), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_second_accept", 128'(cyc - ta), 128'd22);
    wait_drain();
    check("b2b_accepts", 128'(acc_count - acc0), 128'd2);

    // in_valid pulses while busy are ignored
    acc0 = acc_count;
    send(tab[1].key, tab[1].ct, tab[1].pt);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      in_ct    = {$urandom, $urandom, $urandom, $urandom};
      cur_pt   = 128'hdead;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    cur_pt = tab[1].pt;
    wait_drain();
    check("busy_pulse_accepts", 128'(acc_count - acc0), 128'd1);

    // Reset abort at DEC cnt=5 of vector B
    send(tab[0].key, tab[0].ct, tab[0].pt);
    repeat (15) @(posedge clk);
    #1;
    check("abort_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("abort_out", out, 128'd0);
    check("abort_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 128'(in_ready), 128'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("abort_no_out_valid", 128'(seen), 128'd0);
    check("abort_out_held", out, 128'd0);
    @(posedge clk); #1;
    send(tab[1].key, tab[1].ct, tab[1].pt);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
